// File: rtl/ponte_pkg.sv
// rtl/ponte_pkg.sv - shared types and field positions for the HPS->FPGA PIO command bridge
//
// Purpose: opcode and state enumerations plus the bit layout of the 15-bit
// ponte word, {req toggle, opcode[2:0], arg[10:0]}.
// Ports: none (package).
package ponte_pkg;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_SET_LO  = 3'd1,
        OP_SET_HI  = 3'd2,
        OP_WR_PIX  = 3'd3,
        OP_EXEC    = 3'd4,
        OP_COP_RST = 3'd5
    } opcode_e;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        ISSUE,
        WAIT_DONE,
        ACK
    } state_e;

    localparam int TOG_BIT = 14;
    localparam int OP_MSB  = 13;
    localparam int OP_LSB  = 11;
    localparam int ARG_W   = 11;

endpackage

// File: rtl/ponte_cmd_receiver.sv
// rtl/ponte_cmd_receiver.sv - FPGA-side receiver of the toggle-based PIO command bridge
//
// Purpose: registers the ponte word, detects a new command when its toggle
// bit differs from the last one seen, decodes it and either drives the image
// memory write port, pulses the coprocessor soft reset, or runs a
// valid/ready command handshake followed by a wait for cop_done_i. Every
// command finishes by copying the toggle onto status_o.
// Optional macro PONTE_TIMEOUT_EN adds a coprocessor watchdog of TIMEOUT_CYC cycles.
//
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   ponte_word_i  [14] req toggle, [13:11] opcode, [10:0] arg
//   status_o      ack toggle of the last completed command
//   cmd_valid_o / cmd_ready_i / cmd_arg_o   coprocessor command handshake
//   cop_done_i    coprocessor completion pulse
//   cop_rst_o     coprocessor soft-reset pulse
//   mem_we_o / mem_addr_o / mem_data_o      image memory write port
//   err_o         sticky error flag
module ponte_cmd_receiver
    import ponte_pkg::*;
#(
    parameter int ADDR_W      = 17,
    parameter int MEM_DEPTH   = 76800,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [14:0]       ponte_word_i,
    output logic              status_o,
    output logic              cmd_valid_o,
    input  logic              cmd_ready_i,
    output logic [10:0]       cmd_arg_o,
    input  logic              cop_done_i,
    output logic              cop_rst_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_data_o,
    output logic              err_o
);

    state_e              state_q;
    logic [14:0]         ponte_q;
    logic                seen_tog_q;
    logic [2:0]          op_q;
    logic [ARG_W-1:0]    arg_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_inc_d;
    logic                status_q;
    logic                cmd_valid_q;
    logic [ARG_W-1:0]    cmd_arg_q;
    logic                cop_rst_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [7:0]          mem_data_q;
    logic                err_q;

`ifdef PONTE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    logic [CNT_W-1:0] wdog_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC > 0);
`endif

    // Only the last pixel wraps; addresses parked beyond the image by SET_HI
    // simply count up.
    assign addr_inc_d = (addr_q == ADDR_W'(MEM_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ponte_q     <= '0;
            seen_tog_q  <= 1'b0;
            op_q        <= '0;
            arg_q       <= '0;
            addr_q      <= '0;
            status_q    <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_arg_q   <= '0;
            cop_rst_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            err_q       <= 1'b0;
`ifdef PONTE_TIMEOUT_EN
            wdog_q      <= '0;
`endif
        end else begin
            ponte_q   <= ponte_word_i;
            mem_we_q  <= 1'b0;
            cop_rst_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Words that changed while busy are never queued: only the
                    // current ponte_q is looked at here.
                    if (ponte_q[TOG_BIT] != seen_tog_q) begin
                        op_q       <= ponte_q[OP_MSB:OP_LSB];
                        arg_q      <= ponte_q[ARG_W-1:0];
                        seen_tog_q <= ponte_q[TOG_BIT];
                        state_q    <= DECODE;
                    end
                end
                DECODE: begin
                    state_q <= ACK;
                    case (op_q)
                        OP_NOP:    ;
                        OP_SET_LO: addr_q[10:0] <= arg_q;
                        OP_SET_HI: addr_q[ADDR_W-1:11] <= arg_q[ADDR_W-12:0];
                        OP_WR_PIX: begin
                            mem_we_q   <= 1'b1;
                            mem_addr_q <= addr_q;
                            mem_data_q <= arg_q[7:0];
                            addr_q     <= addr_inc_d;
                        end
                        OP_EXEC: begin
                            cmd_valid_q <= 1'b1;
                            cmd_arg_q   <= arg_q;
                            state_q     <= ISSUE;
`ifdef PONTE_TIMEOUT_EN
                            wdog_q      <= '0;
`endif
                        end
                        OP_COP_RST: cop_rst_q <= 1'b1;
                        default:    err_q <= 1'b1;
                    endcase
                end
                ISSUE: begin
                    if (cmd_ready_i) begin
                        cmd_valid_q <= 1'b0;
                        // A done arriving in the handshake cycle itself must not be lost.
                        state_q     <= cop_done_i ? ACK : WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (cop_done_i) begin
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    status_q <= seen_tog_q;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
`ifdef PONTE_TIMEOUT_EN
            // Watchdog overrides the handshake: reset the coprocessor, flag
            // the error and still release the HPS with an ack.
            if (state_q == ISSUE || state_q == WAIT_DONE) begin
                if (wdog_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    cop_rst_q   <= 1'b1;
                    err_q       <= 1'b1;
                    cmd_valid_q <= 1'b0;
                    state_q     <= ACK;
                end else begin
                    wdog_q <= wdog_q + CNT_W'(1);
                end
            end
`endif
        end
    end

    assign status_o    = status_q;
    assign cmd_valid_o = cmd_valid_q;
    assign cmd_arg_o   = cmd_arg_q;
    assign cop_rst_o   = cop_rst_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_data_o  = mem_data_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_ponte_cmd_receiver.sv
// tb/tb_ponte_cmd_receiver.sv - self-checking bench for ponte_cmd_receiver
module tb_ponte_cmd_receiver;

    localparam int MEM_DEPTH = 76800;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] ponte_word_i;
    logic        status_o;
    logic        cmd_valid_o;
    logic        cmd_ready_i;
    logic [10:0] cmd_arg_o;
    logic        cop_done_i;
    logic        cop_rst_o;
    logic        mem_we_o;
    logic [16:0] mem_addr_o;
    logic [7:0]  mem_data_o;
    logic        err_o;

    ponte_cmd_receiver dut (
        .clk          (clk),
        .reset        (reset),
        .ponte_word_i (ponte_word_i),
        .status_o     (status_o),
        .cmd_valid_o  (cmd_valid_o),
        .cmd_ready_i  (cmd_ready_i),
        .cmd_arg_o    (cmd_arg_o),
        .cop_done_i   (cop_done_i),
        .cop_rst_o    (cop_rst_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: the HPS toggle, the image write pointer, the error flag.
    logic tog;
    int   m_addr;
    logic m_err;

    // Observations collected over one simple command's window.
    int          o_stat_cyc;
    int          o_we_cnt;
    int          o_rst_cnt;
    int          o_valid_cnt;
    logic [16:0] o_we_addr;
    logic [7:0]  o_we_data;

    task automatic do_reset();
        reset        = 1'b1;
        ponte_word_i = '0;
        cmd_ready_i  = 1'b0;
        cop_done_i   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        tog    = 1'b0;
        m_addr = 0;
        m_err  = 1'b0;
    endtask

    // Sends one command with a fresh toggle and watches 8 cycles of outputs.
    task automatic drive_cmd(input logic [2:0] op, input logic [10:0] arg);
        logic prev;
        prev         = status_o;
        tog          = ~tog;
        ponte_word_i = {tog, op, arg};
        o_stat_cyc   = 0;
        o_we_cnt     = 0;
        o_rst_cnt    = 0;
        o_valid_cnt  = 0;
        o_we_addr    = '0;
        o_we_data    = '0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (o_stat_cyc == 0 && status_o !== prev) o_stat_cyc = c;
            if (mem_we_o === 1'b1) begin
                o_we_cnt++;
                o_we_addr = mem_addr_o;
                o_we_data = mem_data_o;
            end
            if (cop_rst_o === 1'b1) o_rst_cnt++;
            if (cmd_valid_o === 1'b1) o_valid_cnt++;
        end
    endtask

    // High-level effect of a simple command on the model; returns the write it should cause.
    task automatic model_apply(input logic [2:0] op, input logic [10:0] arg,
                               output int exp_we, output int exp_addr);
        exp_we   = 0;
        exp_addr = m_addr;
        case (op)
            3'd1: m_addr = (m_addr / 2048) * 2048 + int'(arg);
            3'd2: m_addr = (int'(arg) % 64) * 2048 + (m_addr % 2048);
            3'd3: begin
                exp_we = 1;
                m_addr = (m_addr == MEM_DEPTH - 1) ? 0 : (m_addr + 1) % 131072;
            end
            3'd6, 3'd7: m_err = 1'b1;
            default: ;
        endcase
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({status_o, cmd_valid_o, cmd_arg_o, cop_rst_o, mem_we_o, mem_addr_o, mem_data_o, err_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got status=%b valid=%b arg=%h rst=%b we=%b addr=%h data=%h err=%b, expected all 0",
                     status_o, cmd_valid_o, cmd_arg_o, cop_rst_o, mem_we_o, mem_addr_o, mem_data_o, err_o);
        end
    endtask

    task automatic test_basic();
        int ew, ea;
        int stat_ok;
        logic [2:0]  ops  [3] = '{3'd1, 3'd2, 3'd3};
        logic [10:0] args [3] = '{11'h005, 11'h000, 11'h0AB};
        int total_we;
        total_we = 0;
        for (int i = 0; i < 3; i++) begin
            model_apply(ops[i], args[i], ew, ea);
            drive_cmd(ops[i], args[i]);
            total_we += o_we_cnt;
            stat_ok = (status_o === tog) && (o_stat_cyc == 4);
            checks++;
            if (!stat_ok) begin
                errors++;
                $display("FAIL basic_status[%0d]: got status=%b at cycle %0d, expected %b at cycle 4", i, status_o, o_stat_cyc, tog);
            end
        end
        checks++;
        if (total_we != 1 || o_we_addr !== 17'd5 || o_we_data !== 8'hAB) begin
            errors++;
            $display("FAIL basic_write: got %0d writes addr=%0d data=%h, expected 1 write addr=5 data=ab", total_we, o_we_addr, o_we_data);
        end
    endtask

    task automatic test_wrap();
        int ew, ea;
        logic [7:0] pix [2] = '{8'h11, 8'h22};
        int exp_a [2] = '{MEM_DEPTH - 1, 0};
        model_apply(3'd1, 11'((MEM_DEPTH - 1) % 2048), ew, ea);
        drive_cmd(3'd1, 11'((MEM_DEPTH - 1) % 2048));
        model_apply(3'd2, 11'((MEM_DEPTH - 1) / 2048), ew, ea);
        drive_cmd(3'd2, 11'((MEM_DEPTH - 1) / 2048));
        for (int i = 0; i < 2; i++) begin
            model_apply(3'd3, {3'b0, pix[i]}, ew, ea);
            drive_cmd(3'd3, {3'b0, pix[i]});
            checks++;
            if (o_we_cnt != 1 || int'(o_we_addr) != exp_a[i] || o_we_data !== pix[i]) begin
                errors++;
                $display("FAIL wrap_write[%0d]: got %0d writes addr=%0d data=%h, expected 1 write addr=%0d data=%h",
                         i, o_we_cnt, o_we_addr, o_we_data, exp_a[i], pix[i]);
            end
        end
    endtask

    task automatic test_random_simple();
        logic [2:0] pool [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd5};
        logic [2:0]  op;
        logic [10:0] arg;
        int ew, ea;
        for (int i = 0; i < 40; i++) begin
            op  = pool[$urandom_range(0, 5)];
            arg = 11'($urandom);
            model_apply(op, arg, ew, ea);
            drive_cmd(op, arg);
            checks++;
            if (o_stat_cyc != 4 || status_o !== tog) begin
                errors++;
                $display("FAIL rand_status[%0d] op=%0d: got status=%b at cycle %0d, expected %b at cycle 4", i, op, status_o, o_stat_cyc, tog);
            end
            checks++;
            if (o_we_cnt != ew || (ew == 1 && (int'(o_we_addr) != ea || o_we_data !== arg[7:0]))) begin
                errors++;
                $display("FAIL rand_write[%0d] op=%0d: got %0d writes addr=%0d data=%h, expected %0d writes addr=%0d data=%h",
                         i, op, o_we_cnt, o_we_addr, o_we_data, ew, ea, arg[7:0]);
            end
            checks++;
            if (o_rst_cnt != ((op == 3'd5) ? 1 : 0) || o_valid_cnt != 0 || err_o !== m_err) begin
                errors++;
                $display("FAIL rand_side[%0d] op=%0d: got rst=%0d valid=%0d err=%b, expected rst=%0d valid=0 err=%b",
                         i, op, o_rst_cnt, o_valid_cnt, err_o, (op == 3'd5) ? 1 : 0, m_err);
            end
        end
    endtask

    task automatic test_exec();
        logic prev;
        int   vcnt;
        int   bad_arg;
        // A stray done while idle must be ignored.
        prev       = status_o;
        cop_done_i = 1'b1;
        @(posedge clk);
        #1;
        cop_done_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (status_o !== prev || cmd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_done_ignored: got status=%b valid=%b, expected status=%b valid=0", status_o, cmd_valid_o, prev);
        end
        tog          = ~tog;
        ponte_word_i = {tog, 3'd4, 11'h012};
        vcnt    = 0;
        bad_arg = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            cmd_ready_i = 1'b0;
            if (cmd_valid_o === 1'b1) begin
                vcnt++;
                if (cmd_arg_o !== 11'h012) bad_arg++;
                if (vcnt == 6) cmd_ready_i = 1'b1;
            end else if (vcnt > 0) begin
                break;
            end
        end
        cmd_ready_i = 1'b0;
        checks++;
        if (vcnt != 6 || bad_arg != 0) begin
            errors++;
            $display("FAIL exec_handshake: got valid for %0d cycles with %0d bad args, expected 6 cycles arg=012", vcnt, bad_arg);
        end
        repeat (19) @(posedge clk);
        #1;
        checks++;
        if (status_o !== prev) begin
            errors++;
            $display("FAIL exec_no_early_ack: got status=%b, expected %b", status_o, prev);
        end
        cop_done_i = 1'b1;
        @(posedge clk);
        #1;
        cop_done_i = 1'b0;
        checks++;
        if (status_o !== prev) begin
            errors++;
            $display("FAIL exec_ack_not_1cyc: got status=%b one cycle after done, expected %b", status_o, prev);
        end
        @(posedge clk);
        #1;
        checks++;
        if (status_o !== tog) begin
            errors++;
            $display("FAIL exec_ack: got status=%b two cycles after done, expected %b", status_o, tog);
        end
    endtask

    task automatic test_illegal();
        int ew, ea;
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_before_illegal: got %b, expected 0", err_o);
        end
        model_apply(3'd6, 11'($urandom), ew, ea);
        drive_cmd(3'd6, 11'($urandom));
        checks++;
        if (err_o !== 1'b1 || o_stat_cyc != 4 || status_o !== tog) begin
            errors++;
            $display("FAIL illegal_op: got err=%b status=%b at cycle %0d, expected err=1 status=%b at cycle 4", err_o, status_o, o_stat_cyc, tog);
        end
        checks++;
        if (o_we_cnt != 0 || o_valid_cnt != 0 || o_rst_cnt != 0) begin
            errors++;
            $display("FAIL illegal_side: got we=%0d valid=%0d rst=%0d, expected all 0", o_we_cnt, o_valid_cnt, o_rst_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        // Arrange for status to be 1 before the command that gets aborted.
        if (tog == 1'b0) drive_cmd(3'd0, 11'h000);
        tog          = ~tog;
        ponte_word_i = {tog, 3'd4, 11'h3C5};
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(posedge clk);
            #1;
            if (cmd_valid_o === 1'b1) seen = 1;
        end
        checks++;
        if (seen == 0) begin
            errors++;
            $display("FAIL rstmid_valid: got no cmd_valid within 10 cycles, expected assertion");
        end
        cmd_ready_i = 1'b1;
        @(posedge clk);
        #1;
        cmd_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset        = 1'b1;
        ponte_word_i = '0;
        @(posedge clk);
        #1;
        checks++;
        if ({status_o, cmd_valid_o, cmd_arg_o, cop_rst_o, mem_we_o, mem_addr_o, mem_data_o, err_o} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got status=%b valid=%b arg=%h rst=%b we=%b addr=%h data=%h err=%b, expected all 0",
                     status_o, cmd_valid_o, cmd_arg_o, cop_rst_o, mem_we_o, mem_addr_o, mem_data_o, err_o);
        end
        @(posedge clk);
        #1;
        reset  = 1'b0;
        tog    = 1'b0;
        m_addr = 0;
        m_err  = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (status_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_ack: got status=%b, expected 0", status_o);
        end
        drive_cmd(3'd0, 11'h000);
        checks++;
        if (status_o !== 1'b1 || o_stat_cyc != 4 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_next_nop: got status=%b at cycle %0d err=%b, expected status=1 at cycle 4 err=0", status_o, o_stat_cyc, err_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_random_simple();
        test_exec();
        test_illegal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
